shift_unit: RTL and testbench

Parametrised, pipelined barrel shifter for the processor datapath, replacing the single-mode combinational 16-bit left shifter. It adds four shift modes, ALU-style carry and zero flags, configurable width and pipeline depth, a pass-through tag, and valid/ready handshaking on both sides. It sits between operand fetch and writeback in the execute stage.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_stage.sv | 52 +++++
 rtl/shift_unit.sv | 69 ++++++
 tb/tb_shift_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shift modes and mux-level split helpers for shift_unit
package shift_pkg;
    typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_op_t;
    function automatic int lg2(input int w);
        int r = 0;
        while ((1 << r) < w) r++;
        return r;
    endfunction
    function automatic int stage_levels(input int k, input int levels, input int stages);
        return levels / stages + (k < levels % stages ? 1 : 0);
    endfunction
    function automatic int stage_first(input int k, input int levels, input int stages);
        int f = 0;
        for (int j = 0; j < k; j++) f += stage_levels(j, levels, stages);
        return f;
    endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one group of barrel mux levels followed by its pipeline register
module shift_stage import shift_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int LG = 4,
    parameter int TAG_WIDTH = 4,
    parameter int LO = 0,
    parameter int NL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 advance,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_value,
    input  logic                 in_carry,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  shift_op_t            in_op,
    input  logic [LG-1:0]        in_amount,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_value,
    output logic                 out_carry,
    output logic [TAG_WIDTH-1:0] out_tag,
    output shift_op_t            out_op,
    output logic [LG-1:0]        out_amount
);
    logic [WIDTH-1:0] lvl [NL+1];
    assign lvl[0] = in_value;
    for (genvar l = 0; l < NL; l++) begin : g_lvl
        localparam int S = 1 << (LO + l);
        assign lvl[l+1] = !in_amount[LO+l] ? lvl[l] :
                          in_op == SH_LSL ? lvl[l] << S :
                          in_op == SH_LSR ? lvl[l] >> S :
                          in_op == SH_ASR ? $unsigned($signed(lvl[l]) >>> S) :
                          (lvl[l] >> S) | (lvl[l] << (WIDTH - S));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_value  <= '0;
            out_carry  <= 1'b0;
            out_tag    <= '0;
            out_op     <= SH_LSL;
            out_amount <= '0;
        end else if (advance) begin
            out_valid  <= in_valid;
            out_value  <= lvl[NL];
            out_carry  <= in_carry;
            out_tag    <= in_tag;
            out_op     <= in_op;
            out_amount <= in_amount;
        end
    end
endmodule

// File: rtl/shift_unit.sv
// shift_unit: pipelined barrel shifter (LSL/LSR/ASR/ROR) with carry/zero flags and valid/ready
module shift_unit import shift_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int AMT_WIDTH = 8,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_value,
    input  logic [AMT_WIDTH-1:0] in_amount,
    input  logic [1:0]           in_op,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_value,
    output logic                 out_carry,
    output logic                 out_zero,
    output logic [TAG_WIDTH-1:0] out_tag
);
    localparam int LG = lg2(WIDTH);
    logic                 valid  [PIPE_STAGES+1];
    logic [WIDTH-1:0]     value  [PIPE_STAGES+1];
    logic                 carry  [PIPE_STAGES+1];
    logic [TAG_WIDTH-1:0] tag    [PIPE_STAGES+1];
    shift_op_t            op     [PIPE_STAGES+1];
    logic [LG-1:0]        amount [PIPE_STAGES+1];
    logic advance, sat, nz, le;
    logic [LG-1:0] im1, ineg;
    shift_op_t op0;
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;
    assign op0  = shift_op_t'(in_op);
    assign sat  = in_amount >= AMT_WIDTH'(WIDTH);
    assign le   = in_amount <= AMT_WIDTH'(WIDTH);
    assign nz   = |in_amount;
    assign im1  = LG'(in_amount - AMT_WIDTH'(1));
    assign ineg = LG'(AMT_WIDTH'(WIDTH) - in_amount);
    // Saturated non-rotate ops become a zero-distance shift of the forced fill value
    assign valid[0]  = in_valid;
    assign tag[0]    = in_tag;
    assign op[0]     = op0;
    assign value[0]  = sat && op0 != SH_ROR ? (op0 == SH_ASR ? {WIDTH{in_value[WIDTH-1]}} : '0) : in_value;
    assign amount[0] = sat && op0 != SH_ROR ? '0 : in_amount[LG-1:0];
    assign carry[0]  = !nz ? 1'b0 :
                       op0 == SH_LSL ? le && in_value[ineg] :
                       op0 == SH_LSR ? le && in_value[im1] :
                       op0 == SH_ASR ? (sat ? in_value[WIDTH-1] : in_value[im1]) :
                       in_value[im1];
    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        shift_stage #(
            .WIDTH(WIDTH), .LG(LG), .TAG_WIDTH(TAG_WIDTH),
            .LO(stage_first(s, LG, PIPE_STAGES)), .NL(stage_levels(s, LG, PIPE_STAGES))
        ) u_stage (
            .clk(clk), .rst(rst), .advance(advance),
            .in_valid(valid[s]), .in_value(value[s]), .in_carry(carry[s]),
            .in_tag(tag[s]), .in_op(op[s]), .in_amount(amount[s]),
            .out_valid(valid[s+1]), .out_value(value[s+1]), .out_carry(carry[s+1]),
            .out_tag(tag[s+1]), .out_op(op[s+1]), .out_amount(amount[s+1])
        );
    end
    assign out_valid = valid[PIPE_STAGES];
    assign out_value = value[PIPE_STAGES];
    assign out_carry = carry[PIPE_STAGES];
    assign out_tag   = tag[PIPE_STAGES];
    assign out_zero  = out_valid && ~|out_value;
endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: scoreboard bench for shift_unit at PIPE_STAGES 2 (directed) and 1/4 (sweep)
module tb_shift_unit;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic iv0 = 0, ivs = 0, or0 = 1;
    logic [15:0] val = 0;
    logic [7:0] amt = 0;
    logic [1:0] op = 0;
    logic [3:0] tag = 0;
    logic ir0, ir1, ir2, ov0, ov1, ov2, oc0, oc1, oc2, oz0, oz1, oz2;
    logic [15:0] v0, v1, v2;
    logic [3:0] t0, t1, t2;
    int cyc = 0, checks = 0, failures = 0;
    typedef struct { logic [15:0] v; logic c; logic [3:0] t; int cyc; int lat; } exp_t;
    exp_t q0[$], q1[$], q2[$];
    always @(posedge clk) cyc <= cyc + 1;

    shift_unit #(.WIDTH(16), .AMT_WIDTH(8), .PIPE_STAGES(2), .TAG_WIDTH(4)) u_p2 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_value(val), .in_amount(amt),
        .in_op(op), .in_tag(tag), .out_valid(ov0), .out_ready(or0), .out_value(v0),
        .out_carry(oc0), .out_zero(oz0), .out_tag(t0));
    shift_unit #(.WIDTH(16), .AMT_WIDTH(8), .PIPE_STAGES(1), .TAG_WIDTH(4)) u_p1 (
        .clk(clk), .rst(rst), .in_valid(ivs), .in_ready(ir1), .in_value(val), .in_amount(amt),
        .in_op(op), .in_tag(tag), .out_valid(ov1), .out_ready(1'b1), .out_value(v1),
        .out_carry(oc1), .out_zero(oz1), .out_tag(t1));
    shift_unit #(.WIDTH(16), .AMT_WIDTH(8), .PIPE_STAGES(4), .TAG_WIDTH(4)) u_p4 (
        .clk(clk), .rst(rst), .in_valid(ivs), .in_ready(ir2), .in_value(val), .in_amount(amt),
        .in_op(op), .in_tag(tag), .out_valid(ov2), .out_ready(1'b1), .out_value(v2),
        .out_carry(oc2), .out_zero(oz2), .out_tag(t2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic pop(input int id, input exp_t e, input logic [15:0] v, input logic c,
                       input logic z, input logic [3:0] t);
        chk($sformatf("p%0d tag", id), t, e.t);
        chk($sformatf("p%0d value tag%0h", id, e.t), v, e.v);
        chk($sformatf("p%0d carry tag%0h", id, e.t), c, e.c);
        chk($sformatf("p%0d zero tag%0h", id, e.t), z, e.v == 0);
        if (e.lat != 0) chk($sformatf("p%0d latency", id), cyc - e.cyc, e.lat);
    endtask

    task automatic spurious(input int id, input logic [3:0] t);
        checks++;
        failures++;
        $display("FAIL p%0d spurious output: tag %0h with nothing expected", id, t);
    endtask

    always @(negedge clk) if (ov0 && or0) begin
        if (q0.size() == 0) spurious(2, t0); else pop(2, q0.pop_front(), v0, oc0, oz0, t0);
    end
    always @(negedge clk) if (ov1) begin
        if (q1.size() == 0) spurious(1, t1); else pop(1, q1.pop_front(), v1, oc1, oz1, t1);
    end
    always @(negedge clk) if (ov2) begin
        if (q2.size() == 0) spurious(4, t2); else pop(4, q2.pop_front(), v2, oc2, oz2, t2);
    end

    function automatic logic [16:0] model(input logic [15:0] v, input logic [7:0] a, input logic [1:0] o);
        logic [15:0] r = v;
        logic c = 0;
        for (int i = 0; i < int'(a); i++) begin
            c = o == 2'd0 ? r[15] : r[0];
            r = o == 2'd0 ? {r[14:0], 1'b0} : o == 2'd1 ? {1'b0, r[15:1]} :
                o == 2'd2 ? {r[15], r[15:1]} : {r[0], r[15:1]};
        end
        return {c, r};
    endfunction

    task automatic issue0(input logic [15:0] v, input logic [7:0] a, input logic [1:0] o,
                          input logic [3:0] t, input logic [15:0] ev, input logic ec,
                          input int lat, input bit push);
        int n = 0;
        val = v; amt = a; op = o; tag = t; iv0 = 1;
        @(negedge clk);
        while (!ir0 && n < 20) begin n++; @(negedge clk); end
        if (!ir0) begin
            checks++; failures++;
            $display("FAIL in_ready timeout: got 0 want 1 for tag %0h", t);
        end else if (push) q0.push_back('{ev, ec, t, cyc, lat});
        @(posedge clk); #1 iv0 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk("reset out_valid", ov0, 0);
        chk("reset out_value", v0, 0);
        chk("reset out_carry", oc0, 0);
        chk("reset out_zero", oz0, 0);
        chk("reset out_tag", t0, 0);
        chk("reset in_ready", ir0, 1);
        @(posedge clk); #1 rst = 0;
        issue0(16'h8001, 8'd1,   2'd0, 4'h1, 16'h0002, 1, 2, 1);
        issue0(16'h8000, 8'd16,  2'd1, 4'h2, 16'h0000, 1, 0, 1);
        issue0(16'h8000, 8'd17,  2'd1, 4'h3, 16'h0000, 0, 0, 1);
        issue0(16'h8000, 8'd200, 2'd2, 4'h4, 16'hFFFF, 1, 0, 1);
        issue0(16'h0001, 8'd17,  2'd3, 4'h5, 16'h8000, 1, 0, 1);
        issue0(16'h1234, 8'd16,  2'd3, 4'h6, 16'h1234, 0, 0, 1);
        for (int k = 0; k < 4; k++) issue0(16'hA5C3, 8'd0, 2'(k), 4'(8 + k), 16'hA5C3, 0, 0, 1);
        issue0(16'h0001, 8'd16,  2'd0, 4'h7, 16'h0000, 1, 0, 1);
        issue0(16'h4000, 8'd15,  2'd2, 4'hC, 16'h0000, 1, 0, 1);
        issue0(16'h00F8, 8'd4,   2'd1, 4'hD, 16'h000F, 1, 0, 1);
        issue0(16'h00F0, 8'd4,   2'd3, 4'hE, 16'h000F, 0, 0, 1);
        issue0(16'h00FF, 8'd4,   2'd0, 4'hF, 16'h0FF0, 0, 0, 1);
        repeat (5) @(posedge clk);
        #1;
        fork
            begin
                for (int k = 1; k <= 4; k++) issue0(16'h0001, 8'(k), 2'd0, 4'(k), 16'(1 << k), 0, 0, 1);
            end
            begin
                int n = 0;
                do begin @(posedge clk); #1; n++; end while (!ov0 && n < 20);
                chk("first result valid", ov0, 1);
                or0 = 0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall in_ready", ir0, 0);
                    chk("stall value", v0, 16'h0002);
                    chk("stall tag", t0, 4'h1);
                end
                @(posedge clk); #1 or0 = 1;
            end
        join
        repeat (6) @(posedge clk);
        #1 or0 = 0;
        issue0(16'h1111, 8'd1, 2'd0, 4'hA, 16'h0, 0, 0, 0);
        issue0(16'h2222, 8'd1, 2'd0, 4'hB, 16'h0, 0, 0, 0);
        chk("in-flight out_valid", ov0, 1);
        #2 rst = 1;
        #1;
        chk("async reset out_valid", ov0, 0);
        chk("async reset out_value", v0, 0);
        chk("async reset out_carry", oc0, 0);
        chk("async reset out_zero", oz0, 0);
        chk("async reset out_tag", t0, 0);
        chk("async reset in_ready", ir0, 1);
        @(posedge clk); #1;
        or0 = 1; rst = 0;
        issue0(16'h00F8, 8'd4, 2'd1, 4'h9, 16'h000F, 1, 2, 1);
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < 300; i++) begin
            logic [16:0] m;
            val = 16'($urandom);
            amt = (i % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 33));
            op = 2'($urandom);
            tag = 4'($urandom);
            ivs = (i % 7 != 6);
            m = model(val, amt, op);
            @(negedge clk);
            if (ivs) begin
                q1.push_back('{m[15:0], m[16], tag, cyc, 1});
                q2.push_back('{m[15:0], m[16], tag, cyc, 4});
            end
            @(posedge clk); #1;
        end
        ivs = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("p2 scoreboard drained", q0.size(), 0);
        chk("p1 scoreboard drained", q1.size(), 0);
        chk("p4 scoreboard drained", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
